opcode_issue_seq: RTL and testbench
===================================

Name: opcode_issue_seq

Overview:
- Instruction issue sequencer upstream of the opcode decoder.
- Accepts 16-bit instruction words from instruction memory over a valid/ready handshake and buffers them in a small FIFO.
- Presents one opcode per issue slot to the decoder.
- Inserts stall cycles for multi-cycle mul/div, holds after branches until resolution, and flushes the buffer on a taken branch.

Parameters:
- DEPTH, 2, instruction buffer entries (power of two, ≥2).
- MUL_CYC, 3, total issue-slot cycles occupied by mul (≥1).
- DIV_CYC, 8, total issue-slot cycles occupied by div (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ins_valid  in  1  instruction word valid.
- ins_data  in  16  instruction word; [15:11] opcode, [10:0] operand field.
- ins_ready  out  1  sequencer can accept a word this cycle.
- op_valid  out  1  opcode/operand valid for decoder (one-cycle pulse per instruction).
- opcode  out  5  issued opcode.
- operand  out  11  issued operand field.
- br_resolve  in  1  branch outcome valid (one-cycle pulse).
- br_taken  in  1  branch taken; sampled only when br_resolve=1.
- busy  out  1  instruction in buffer, multi-cycle stall, or branch wait active.
- illegal  out  1  one-cycle pulse when an unlisted opcode is issued.

Behaviour:
- Opcode map (5-bit): add 00000, lw 00001, sw 00010, and 00100, andi 00101, sub 01000, bnq 01001, mul 01100, div 01101, xor 01111.
- Any other opcode is issued as NOP: opcode 5'b10000, operand 0, op_valid=1, illegal=1 in the same cycle.
- Reset (async, immediate): op_valid=0, opcode=0, operand=0, illegal=0, busy=0, ins_ready=0 while rst=1.
  - FIFO pointers and count go to 0; FSM goes to IDLE.
  - ins_ready=1 from the first cycle after rst deasserts.
  - Reset mid-multi-cycle or mid-branch-wait discards all state.
- Buffer:
  - Push on ins_valid&&ins_ready.
  - ins_ready = (count<DEPTH) && state!=FLUSH.
  - A pop and a push in the same cycle are legal when full; count is unchanged and ins_ready stays 1 because a pop is pending.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, MULTI, BR_WAIT, FLUSH.
  - IDLE: buffer empty; op_valid=0. A word pushed in cycle N issues at cycle N+1 (registered outputs; latency 1).
  - ISSUE: each cycle the head is popped and registered to the outputs with op_valid=1.
    - mul → MULTI with counter=MUL_CYC-1.
    - div → MULTI with counter=DIV_CYC-1.
    - bnq → BR_WAIT.
    - If the buffer is empty after the pop → IDLE; otherwise stay.
    - If the counter load value is 0, the FSM proceeds as for a single-cycle op.
  - MULTI: op_valid=0. Counter decrements each cycle; at 0 → ISSUE if buffer non-empty, else IDLE. Buffer still accepts pushes.
  - BR_WAIT: op_valid=0; pushes are accepted.
    - br_resolve&&!br_taken → ISSUE/IDLE per buffer.
    - br_resolve&&br_taken → FLUSH.
    - br_resolve arriving in the same cycle bnq is issued is honored in the next cycle only; it must not arrive earlier.
  - FLUSH: one cycle. Count and pointers are cleared, any simultaneous push is dropped (ins_ready=0), op_valid=0 → IDLE.
- br_resolve outside BR_WAIT is ignored.
- busy = (count!=0) || state ∈ {ISSUE, MULTI, BR_WAIT, FLUSH}.
- opcode and operand hold their last issued values while op_valid=0.

Optional Feature:
- Macro: OPCODE_ISSUE_PERF_EN.
- Defined:
  - Adds output port issue_cnt (16 bits), counting op_valid pulses (NOP included). Wraps 16'hFFFF→0 and resets to 0.
  - Adds output port stall_cnt (16 bits), counting MULTI+BR_WAIT cycles. Saturates at 16'hFFFF and resets to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - Opcode localparams (OP_ADD…OP_XOR, OP_NOP=5'b10000).
  - Field slice constants OPC_MSB=15, OPC_LSB=11, OPR_W=11.
  - FSM state encoding typedef.
  - The same opcode constants are also used by the decoder.
- One sub-module: issue_fifo, the parameterised DEPTH×16 synchronous FIFO.
  - Ports: push, pop, din, dout, count, full, empty, clr.
  - Same clk/rst.
- The sequencer FSM, counter and output registers stay in the top module.

Test Plan:
- Reset then push add (16'h0005) → next cycle op_valid=1, opcode=00000, operand=11'h005; busy drops to 0 the cycle after.
- Push mul, then add back-to-back, MUL_CYC=3 → mul issues cycle N, op_valid=0 for N+1..N+2, add issues at N+3.
- Push bnq, add; assert br_resolve=1, br_taken=1 two cycles later → add never issues, FLUSH cycle has ins_ready=0, then IDLE with count=0.
- Same as above with br_taken=0 → add issues the cycle after the resolve.
- Fill the FIFO while in MULTI (div, DIV_CYC=8) → ins_ready=0 at count=DEPTH. Simultaneous push/pop at full keeps count=DEPTH, and wrap-around order is preserved.
- Push opcode 5'b00011 → issues opcode=10000, operand=0, illegal=1 for one cycle. Assert rst mid-MULTI → all outputs 0 immediately and the buffer is empty.

Source files
------------

// File: rtl/opcode_issue_seq_pkg.sv
// opcode_issue_seq_pkg: shared opcode map, instruction field slices and sequencer state encoding
package opcode_issue_seq_pkg;
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_LW   = 5'b00001;
  localparam logic [4:0] OP_SW   = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_ANDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_BNQ  = 5'b01001;
  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_XOR  = 5'b01111;
  localparam logic [4:0] OP_NOP  = 5'b10000;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int OPR_W = 11;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ISSUE   = 3'd1;
  localparam state_t S_MULTI   = 3'd2;
  localparam state_t S_BR_WAIT = 3'd3;
  localparam state_t S_FLUSH   = 3'd4;
  function automatic logic op_legal(input logic [4:0] op);
    return op inside {OP_ADD, OP_LW, OP_SW, OP_AND, OP_ANDI, OP_SUB, OP_BNQ, OP_MUL, OP_DIV, OP_XOR};
  endfunction
endpackage

// File: rtl/opcode_issue_seq_if.sv
// opcode_issue_seq_if: instruction fetch handshake, branch resolution and decoder issue bus
interface opcode_issue_seq_if;
  logic        ins_valid;
  logic [15:0] ins_data;
  logic        ins_ready;
  logic        op_valid;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic        br_resolve;
  logic        br_taken;
  logic        busy;
  logic        illegal;
  modport master (
    output ins_valid, ins_data, br_resolve, br_taken,
    input  ins_ready, op_valid, opcode, operand, busy, illegal
  );
  modport slave (
    input  ins_valid, ins_data, br_resolve, br_taken,
    output ins_ready, op_valid, opcode, operand, busy, illegal
  );
endinterface

// File: rtl/opcode_issue_seq_issue_fifo.sv
// issue_fifo: DEPTH x 16 show-ahead synchronous FIFO with synchronous clear
module issue_fifo #(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clr) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/opcode_issue_seq.sv
// opcode_issue_seq: instruction issue sequencer with mul/div stalls and branch hold/flush; OPCODE_ISSUE_PERF_EN adds issue_cnt/stall_cnt
module opcode_issue_seq
  import opcode_issue_seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int MUL_CYC = 3,
  parameter int DIV_CYC = 8
) (
  input logic clk,
  input logic rst,
  opcode_issue_seq_if.slave bus
`ifdef OPCODE_ISSUE_PERF_EN
  ,
  output logic [15:0] issue_cnt,
  output logic [15:0] stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2((MUL_CYC > DIV_CYC ? MUL_CYC : DIV_CYC) + 1);
  state_t state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic br_q, op_valid_q, illegal_q;
  logic legal, wait_br, can_try, issue, pop, push, fifo_push, full, empty, ready;
  logic [4:0] opcode_q, opcode_d, opc;
  logic [OPR_W-1:0] operand_q, operand_d;
  logic [15:0] dout, word;
  logic [CW-1:0] count;
  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(fifo_push),
    .pop(pop),
    .clr(state_q == S_FLUSH),
    .din(bus.ins_data),
    .dout(dout),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    wait_br = state_q == S_BR_WAIT || (state_q == S_ISSUE && br_q);
    can_try = state_q == S_IDLE || (state_q == S_ISSUE && cnt_q == '0 && !br_q) ||
              (state_q == S_MULTI && cnt_q == '0) || (wait_br && bus.br_resolve && !bus.br_taken);
    pop = can_try && !empty;
    ready = !rst && state_q != S_FLUSH && (!full || pop);
    push = bus.ins_valid && ready;
    issue = can_try && (!empty || push);
    fifo_push = push && !(issue && empty);
    word = empty ? bus.ins_data : dout;
    opc = word[OPC_MSB:OPC_LSB];
    legal = op_legal(opc);
    opcode_d = legal ? opc : OP_NOP;
    operand_d = legal ? word[OPR_W-1:0] : '0;
    cnt_d = issue ? (opc == OP_MUL ? NW'(MUL_CYC - 1) : opc == OP_DIV ? NW'(DIV_CYC - 1) : '0)
          : cnt_q != '0 ? cnt_q - NW'(1) : '0;
    state_d = issue ? S_ISSUE
            : state_q == S_FLUSH ? S_IDLE
            : wait_br && !bus.br_resolve ? S_BR_WAIT
            : wait_br && bus.br_taken ? S_FLUSH
            : cnt_q != '0 ? S_MULTI : S_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      br_q <= 1'b0;
      op_valid_q <= 1'b0;
      illegal_q <= 1'b0;
      opcode_q <= '0;
      operand_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      br_q <= issue && opc == OP_BNQ;
      op_valid_q <= issue;
      illegal_q <= issue && !legal;
      if (issue) begin
        opcode_q <= opcode_d;
        operand_q <= operand_d;
      end
    end
  assign bus.ins_ready = ready;
  assign bus.op_valid = op_valid_q;
  assign bus.opcode = opcode_q;
  assign bus.operand = operand_q;
  assign bus.illegal = illegal_q;
  assign bus.busy = count != '0 || state_q != S_IDLE;
`ifdef OPCODE_ISSUE_PERF_EN
  logic [15:0] issue_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_q + 16'(issue);
      if ((state_q == S_MULTI || state_q == S_BR_WAIT) && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  assign issue_cnt = issue_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_opcode_issue_seq.sv
// tb_opcode_issue_seq: directed self-checking bench for opcode_issue_seq
module tb_opcode_issue_seq;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  opcode_issue_seq_if bus ();
`ifdef OPCODE_ISSUE_PERF_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif
  opcode_issue_seq #(.DEPTH(2), .MUL_CYC(3), .DIV_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef OPCODE_ISSUE_PERF_EN
    ,
    .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic r = 1'b0, input logic t = 1'b0);
    @(posedge clk);
    #1;
    bus.ins_valid = v;
    bus.ins_data = d;
    bus.br_resolve = r;
    bus.br_taken = t;
    #4;
  endtask
  initial begin
    bus.ins_valid = 1'b0;
    bus.ins_data = '0;
    bus.br_resolve = 1'b0;
    bus.br_taken = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_op_valid", bus.op_valid, 0);
    chk("rst_opcode", bus.opcode, 0);
    chk("rst_operand", bus.operand, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ins_ready", bus.ins_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("post_rst_ready", bus.ins_ready, 1);
    step(1, 16'h0005);
    chk("add_ready", bus.ins_ready, 1);
    chk("add_pre_valid", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("add_valid", bus.op_valid, 1);
    chk("add_opcode", bus.opcode, 5'b00000);
    chk("add_operand", bus.operand, 11'h005);
    chk("add_busy", bus.busy, 1);
    chk("add_illegal", bus.illegal, 0);
    step(0, 16'h0000);
    chk("add_done_valid", bus.op_valid, 0);
    chk("add_done_busy", bus.busy, 0);
    chk("add_hold_operand", bus.operand, 11'h005);
    step(1, 16'h600A);
    step(1, 16'h0007);
    chk("mul_valid", bus.op_valid, 1);
    chk("mul_opcode", bus.opcode, 5'b01100);
    chk("mul_operand", bus.operand, 11'h00A);
    step(0, 16'h0000);
    chk("mul_stall1", bus.op_valid, 0);
    chk("mul_stall1_busy", bus.busy, 1);
    step(0, 16'h0000);
    chk("mul_stall2", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("mul_next_valid", bus.op_valid, 1);
    chk("mul_next_opcode", bus.opcode, 5'b00000);
    chk("mul_next_operand", bus.operand, 11'h007);
    step(0, 16'h0000);
    chk("mul_end_busy", bus.busy, 0);
    step(1, 16'h4810);
    step(1, 16'h0003);
    chk("bnqt_valid", bus.op_valid, 1);
    chk("bnqt_opcode", bus.opcode, 5'b01001);
    step(0, 16'h0000, 1, 1);
    chk("bnqt_wait_valid", bus.op_valid, 0);
    chk("bnqt_wait_busy", bus.busy, 1);
    step(1, 16'h0004);
    chk("flush_ready", bus.ins_ready, 0);
    chk("flush_valid", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("post_flush_busy", bus.busy, 0);
    chk("post_flush_ready", bus.ins_ready, 1);
    chk("post_flush_valid", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("flushed_no_issue", bus.op_valid, 0);
    chk("flushed_opcode_hold", bus.opcode, 5'b01001);
    step(1, 16'h4811);
    step(1, 16'h0006);
    chk("bnqn_valid", bus.op_valid, 1);
    chk("bnqn_operand", bus.operand, 11'h011);
    step(0, 16'h0000, 1, 0);
    chk("bnqn_wait_valid", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("bnqn_next_valid", bus.op_valid, 1);
    chk("bnqn_next_operand", bus.operand, 11'h006);
    step(0, 16'h0000);
    chk("bnqn_end_busy", bus.busy, 0);
    step(1, 16'h6801);
    step(1, 16'h0011);
    chk("div_valid", bus.op_valid, 1);
    chk("div_opcode", bus.opcode, 5'b01101);
    step(1, 16'h0022);
    chk("div_stall_valid", bus.op_valid, 0);
    step(1, 16'h0033);
    chk("full_ready", bus.ins_ready, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 16'h0033);
      chk("full_hold_valid", bus.op_valid, 0);
    end
    step(1, 16'h0033);
    chk("full_pop_ready", bus.ins_ready, 1);
    chk("div_last_stall", bus.op_valid, 0);
    step(0, 16'h0000);
    chk("wrap_a_valid", bus.op_valid, 1);
    chk("wrap_a_operand", bus.operand, 11'h011);
    chk("wrap_full_ready", bus.ins_ready, 1);
    step(0, 16'h0000);
    chk("wrap_b_operand", bus.operand, 11'h022);
    step(0, 16'h0000);
    chk("wrap_c_valid", bus.op_valid, 1);
    chk("wrap_c_operand", bus.operand, 11'h033);
    step(0, 16'h0000);
    chk("wrap_end_valid", bus.op_valid, 0);
    chk("wrap_end_busy", bus.busy, 0);
    step(1, 16'h1ABC);
    step(0, 16'h0000);
    chk("ill_valid", bus.op_valid, 1);
    chk("ill_opcode", bus.opcode, 5'b10000);
    chk("ill_operand", bus.operand, 0);
    chk("ill_flag", bus.illegal, 1);
    step(0, 16'h0000);
    chk("ill_pulse_end", bus.illegal, 0);
    step(1, 16'h6005);
    step(1, 16'h0009);
    step(0, 16'h0000);
    chk("rmid_stall", bus.op_valid, 0);
    chk("rmid_busy", bus.busy, 1);
`ifdef OPCODE_ISSUE_PERF_EN
    chk("perf_issue_cnt", issue_cnt, 12);
    chk("perf_stall_cnt", stall_cnt, 11);
`endif
    rst = 1'b1;
    #1;
    chk("rmid_op_valid", bus.op_valid, 0);
    chk("rmid_opcode", bus.opcode, 0);
    chk("rmid_operand", bus.operand, 0);
    chk("rmid_busy0", bus.busy, 0);
    chk("rmid_ready", bus.ins_ready, 0);
`ifdef OPCODE_ISSUE_PERF_EN
    chk("perf_issue_rst", issue_cnt, 0);
    chk("perf_stall_rst", stall_cnt, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #4;
    chk("rmid_after_ready", bus.ins_ready, 1);
    step(0, 16'h0000);
    chk("rmid_empty_valid", bus.op_valid, 0);
    chk("rmid_empty_busy", bus.busy, 0);
    step(0, 16'h0000);
    chk("rmid_empty_valid2", bus.op_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
